// File: rtl/systolic_ctrl.sv
// Operand buffering and skewed edge sequencing for an N x N pe array.
// Optional SYSTOLIC_CTRL_ACCUM_EN: accumulate input skips the array clear.
module systolic_ctrl #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [IDX_W-1:0]        wr_row,
    input  logic [IDX_W-1:0]        wr_col,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    start,
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    input  logic                    accumulate,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    arr_rst_n,
    output logic                    arr_we,
    output logic [N*DATA_WIDTH-1:0] a_edge,
    output logic [N*DATA_WIDTH-1:0] b_edge
);

    localparam int CW = $clog2(3 * N);
    localparam logic [CW-1:0] T_LAST = CW'(3 * N - 2);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        COMPUTE,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   t;
    logic            skip_clear;
    logic            wr_ok;

    logic [DATA_WIDTH-1:0] a_buf [N][N];
    logic [DATA_WIDTH-1:0] b_buf [N][N];

`ifdef SYSTOLIC_CTRL_ACCUM_EN
    assign skip_clear = accumulate;
`else
    assign skip_clear = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        t     <= '0;
                        state <= skip_clear ? COMPUTE : CLEAR;
                    end
                end
                CLEAR: begin
                    t     <= '0;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    if (t == T_LAST) state <= DONE;
                    else             t     <= t + 1'b1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    // Host writes only land while the array is not consuming the buffers.
    assign wr_ok = wr_en && (state == IDLE || state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (wr_sel) b_buf[wr_row][wr_col] <= wr_data;
            else        a_buf[wr_row][wr_col] <= wr_data;
        end
    end

    assign busy      = (state == CLEAR) || (state == COMPUTE);
    assign done      = (state == DONE);
    assign arr_we    = (state == COMPUTE);
    assign arr_rst_n = !rst && (state != CLEAR);

    // Row i / column j run i (j) steps behind, forming the diagonal wavefront.
    always_comb begin
        a_edge = '0;
        b_edge = '0;
        if (state == COMPUTE) begin
            for (int i = 0; i < N; i++) begin
                if (t >= CW'(i) && t < CW'(i + N)) begin
                    a_edge[i*DATA_WIDTH +: DATA_WIDTH] =
                        a_buf[i][IDX_W'(t - CW'(i))];
                    b_edge[i*DATA_WIDTH +: DATA_WIDTH] =
                        b_buf[IDX_W'(t - CW'(i))][i];
                end
            end
        end
    end

endmodule
